la_seq: RTL
===========

# la_seq

Segmented-acquisition sequencer for the logic analyzer acquisition engine. It runs a programmed number of back-to-back acquisitions (segments) without software intervention. For each segment it issues reset and start pulses to the engine, forces a software trigger when a trigger timeout expires, and inserts a holdoff between segments. It sits between the system-bus regset and the engine's `ctl_*`/`irq_*` pins, and reports progress counters and timestamps back to the regset.

## Interface
- `SW`, 16: segment counter width.
- `HW`, 32: holdoff/timeout counter width.
- `TW`, 64: timestamp width.

Ports:
- `clk`  in  1  system clock; all logic is on this single clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ctl_str`  in  1  sequence start pulse.
- `ctl_abt`  in  1  sequence abort pulse.
- `cfg_num`  in  SW  segments per sequence; 0 = run until abort.
- `cfg_hld`  in  HW  holdoff cycles between a segment stop and the next reset.
- `cfg_tmo`  in  HW  trigger timeout in cycles; 0 = disabled.
- `cts`  in  TW  current timestamp.
- `irq_trg`  in  1  engine trigger pulse.
- `irq_stp`  in  1  engine stop pulse.
- `acq_rst`  out  1  engine reset pulse.
- `acq_acq`  out  1  engine start pulse.
- `acq_trg`  out  1  forced software trigger pulse.
- `acq_stp`  out  1  engine stop pulse, issued on abort.
- `sts_run`  out  1  sequence active.
- `sts_abt`  out  1  last sequence ended by abort.
- `sts_seg`  out  SW  completed segments.
- `sts_tmo`  out  SW  segments whose trigger was forced.
- `cts_seg`  out  TW  timestamp of the last segment stop.
- `irq_seg`  out  1  segment-complete pulse.
- `irq_seq`  out  1  sequence-complete pulse.

## Operation
- All outputs are registered. Reset value is 0 for every output; after reset the state is IDLE.
- FSM states: IDLE, RST, ARM, WTRG, WSTP, HOLD.
- **IDLE:**
  - `ctl_str`=1 and `ctl_abt`=0 → RST. On the same edge: clear `sts_seg`, `sts_tmo`, `sts_abt`; set `sts_run`.
  - `ctl_str` and `ctl_abt` in the same cycle: abort wins and the block stays in IDLE.
- **RST:** `acq_rst`=1 for one cycle → ARM.
- **ARM:** `acq_acq`=1 for one cycle → WTRG; timeout counter cleared.
- **WTRG:**
  - Timeout counter increments each cycle.
  - When `cfg_tmo`≠0 and the count reaches `cfg_tmo`: `acq_trg`=1 for one cycle, `sts_tmo`+1, → WSTP.
  - `irq_trg` → WSTP. If `irq_trg` and the timeout fall in the same cycle, `irq_trg` wins: no `acq_trg` and no `sts_tmo` increment.
  - `irq_stp` in WTRG is handled as a segment end, same as in WSTP.
- **WSTP:** `irq_stp` → segment end.
- **Segment end:**
  - `sts_seg`+1, `cts_seg`←`cts`, `irq_seg`=1.
  - If `cfg_num`≠0 and the new `sts_seg`==`cfg_num`: `irq_seq`=1, `sts_run`=0 → IDLE.
  - Otherwise, if `cfg_hld`==0 → RST; else → HOLD with the holdoff counter cleared.
- **HOLD:** counts cycles; after `cfg_hld` cycles → RST.
- **Abort:**
  - `ctl_abt` in any non-IDLE state: `acq_stp`=1 for one cycle, `sts_abt`=1, `sts_run`=0 → IDLE. No `irq_seg` or `irq_seq`.
  - Abort has priority over `irq_trg`/`irq_stp` in the same cycle.
- `ctl_str` while `sts_run`=1 is ignored.
- `cfg_*` are sampled live; software changes them only while idle.
- Arithmetic:
  - `sts_seg`/`sts_tmo` wrap modulo 2^SW; wrap is only reachable with `cfg_num`=0.
  - Holdoff and timeout counters are HW bits and compare for equality with the cfg value, so they never wrap.
- `rst` mid-sequence: returns to IDLE with all outputs 0 on the next edge. No `acq_stp` is issued; the engine is reset on the same bus reset.

## Timing
- `ctl_str` sampled at edge N → `acq_rst` high in cycle N+1 → `acq_acq` in N+2 → WTRG from N+3.
- Timeout: `acq_trg` asserts `cfg_tmo` cycles after WTRG entry (first WTRG cycle counts as 1).
- `irq_stp` at edge M → `irq_seg`/`cts_seg` valid in cycle M+1 (`cts_seg` = `cts` value at edge M).
- With `cfg_hld`=0: next `acq_rst` in M+1, so segment pitch is stop+1.
- With `cfg_hld`=H: next `acq_rst` in M+1+H.
- `irq_seq` coincides with the final `irq_seg`.
- `ctl_abt` at edge K → `acq_stp` in K+1, `sts_run`=0 in K+1.
- All pulse outputs are exactly one cycle wide, and at most one of `acq_rst`/`acq_acq`/`acq_trg`/`acq_stp` is high in any cycle.

## Test plan
- **Basic sequence.** `cfg_num`=3, `cfg_hld`=0, `cfg_tmo`=0; engine model returns `irq_trg` 5 cycles after `acq_acq`, then `irq_stp` 10 cycles later.
  - Required: 3 `acq_rst`/`acq_acq` pairs, `irq_seg`×3, `irq_seq` on the third, `sts_seg`=3, `sts_run`=0.
- **Timeout.** `cfg_tmo`=20, model never triggers.
  - Required: `acq_trg` exactly 20 cycles after WTRG entry; `sts_tmo`=1 after `irq_stp`.
- **Holdoff.** `cfg_hld`=7.
  - Required: `acq_rst` exactly 8 cycles after each non-final `irq_stp` edge; `cts_seg` equals `cts` at the `irq_stp` edge.
- **Abort mid-segment.** `cfg_num`=0; abort in WSTP coincident with `irq_stp`.
  - Required: `acq_stp` one cycle later, no `irq_seg`, `sts_abt`=1, `sts_seg` unchanged.
- **Simultaneous events.**
  - `irq_trg` on the timeout cycle → no `acq_trg`, `sts_tmo`=0.
  - `ctl_str`+`ctl_abt` in IDLE → stays IDLE.
  - `ctl_str` while running → ignored.
- **Reset mid-sequence.** Assert `rst` in HOLD.
  - Required: next cycle all outputs 0, no pulses; a subsequent `ctl_str` runs a clean sequence from `sts_seg`=0.

Source files
------------

// File: rtl/la_seq.sv
// la_seq: segmented-acquisition sequencer driving the logic analyzer engine
module la_seq #(
    parameter int SW = 16,
    parameter int HW = 32,
    parameter int TW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ctl_str,
    input  logic          ctl_abt,
    input  logic [SW-1:0] cfg_num,
    input  logic [HW-1:0] cfg_hld,
    input  logic [HW-1:0] cfg_tmo,
    input  logic [TW-1:0] cts,
    input  logic          irq_trg,
    input  logic          irq_stp,
    output logic          acq_rst,
    output logic          acq_acq,
    output logic          acq_trg,
    output logic          acq_stp,
    output logic          sts_run,
    output logic          sts_abt,
    output logic [SW-1:0] sts_seg,
    output logic [SW-1:0] sts_tmo,
    output logic [TW-1:0] cts_seg,
    output logic          irq_seg,
    output logic          irq_seq
);
    localparam logic [2:0] IDLE = 3'd0, RST = 3'd1, ARM = 3'd2, WTRG = 3'd3, WSTP = 3'd4, HOLD = 3'd5;
    logic [2:0]    st;
    logic [HW-1:0] tcnt, hcnt, tcnt_nx, hcnt_nx;
    logic [SW-1:0] seg_nx;
    logic          seg_end, seg_last, tmo_hit;
    assign tcnt_nx  = tcnt + HW'(1);
    assign hcnt_nx  = hcnt + HW'(1);
    assign seg_nx   = sts_seg + SW'(1);
    assign seg_end  = (st == WTRG || st == WSTP) && irq_stp;
    assign seg_last = (cfg_num != '0) && (seg_nx == cfg_num);
    assign tmo_hit  = (cfg_tmo != '0) && (tcnt_nx == cfg_tmo);
    // Pulse outputs are raised on the edge that enters the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= IDLE;
            tcnt    <= '0;
            hcnt    <= '0;
            acq_rst <= 1'b0;
            acq_acq <= 1'b0;
            acq_trg <= 1'b0;
            acq_stp <= 1'b0;
            sts_run <= 1'b0;
            sts_abt <= 1'b0;
            sts_seg <= '0;
            sts_tmo <= '0;
            cts_seg <= '0;
            irq_seg <= 1'b0;
            irq_seq <= 1'b0;
        end else begin
            acq_rst <= 1'b0;
            acq_acq <= 1'b0;
            acq_trg <= 1'b0;
            acq_stp <= 1'b0;
            irq_seg <= 1'b0;
            irq_seq <= 1'b0;
            if (st != IDLE && ctl_abt) begin
                st      <= IDLE;
                acq_stp <= 1'b1;
                sts_abt <= 1'b1;
                sts_run <= 1'b0;
            end else if (seg_end) begin
                sts_seg <= seg_nx;
                cts_seg <= cts;
                irq_seg <= 1'b1;
                if (seg_last) begin
                    st      <= IDLE;
                    irq_seq <= 1'b1;
                    sts_run <= 1'b0;
                end else if (cfg_hld == '0) begin
                    st      <= RST;
                    acq_rst <= 1'b1;
                end else begin
                    st   <= HOLD;
                    hcnt <= '0;
                end
            end else begin
                case (st)
                    IDLE: if (ctl_str && !ctl_abt) begin
                        st      <= RST;
                        acq_rst <= 1'b1;
                        sts_seg <= '0;
                        sts_tmo <= '0;
                        sts_abt <= 1'b0;
                        sts_run <= 1'b1;
                    end
                    RST: begin
                        st      <= ARM;
                        acq_acq <= 1'b1;
                    end
                    ARM: begin
                        st   <= WTRG;
                        tcnt <= '0;
                    end
                    WTRG: begin
                        tcnt <= tcnt_nx;
                        if (irq_trg) st <= WSTP;
                        else if (tmo_hit) begin
                            st      <= WSTP;
                            acq_trg <= 1'b1;
                            sts_tmo <= sts_tmo + SW'(1);
                        end
                    end
                    WSTP: st <= WSTP;
                    HOLD: if (hcnt_nx == cfg_hld) begin
                        st      <= RST;
                        acq_rst <= 1'b1;
                    end else hcnt <= hcnt_nx;
                    default: st <= IDLE;
                endcase
            end
        end
    end
endmodule
